// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller for a 16-bit ALU.
//
// Holds a program memory (PROG_DEPTH x 16) and a 16x16 register file. It
// fetches one instruction at a time, drives opcode/A/B into the ALU, waits
// ALU_LATENCY cycles, then writes the ALU result back. Each instruction fully
// retires before the next fetch, so there are no register hazards.
//
// Instruction word: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb
//   ALU ops 0100 ADD, 0101 SUB, 1000 AND, 1001 OR, 1010 XOR, 1011 NAND,
//           1100 NOR, 1101 NOT
//   0000 NOP, 0001 CLR rd, 1111 HALT, anything else is illegal (sets err).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   prog_we/addr/data        program load (accepted in IDLE only)
//   reg_we/addr/wdata        register preload (accepted in IDLE only)
//   reg_rdata                combinational read of rf[reg_addr]
//   start                    begin at pc=0 (IDLE only)
//   busy, done, err          status: busy in FETCH..WB, done pulse, sticky err
//   alu_opcode/alu_a/alu_b   registered ALU operands
//   alu_result               ALU result, sampled in WB
//
// Optional feature (macro SEQ_FLAGS_EN): adds zero_flag/neg_flag outputs,
// updated on every writeback and by CLR.

module alu_sequencer #(
   parameter int PROG_DEPTH  = 16,
   parameter int ALU_LATENCY = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          prog_we,
   input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
   input  logic [15:0]                   prog_data,
   input  logic                          reg_we,
   input  logic [3:0]                    reg_addr,
   input  logic [15:0]                   reg_wdata,
   output logic [15:0]                   reg_rdata,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [3:0]                    alu_opcode,
   output logic [15:0]                   alu_a,
   output logic [15:0]                   alu_b,
   input  logic [15:0]                   alu_result
`ifdef SEQ_FLAGS_EN
   ,
   output logic                          zero_flag,
   output logic                          neg_flag
`endif
);

   localparam int PW = $clog2(PROG_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WB, S_DONE
   } state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   pc;
   logic [15:0]     ir;
   logic [2:0]      wcnt;
   logic [15:0]     prog [PROG_DEPTH];
   logic [15:0]     rf   [16];

   logic [3:0]      op, rd, ra, rb;
   logic            is_alu, is_nop, is_clr, is_halt, is_ill;
   logic            last_pc;

   assign op = ir[15:12];
   assign rd = ir[11:8];
   assign ra = ir[7:4];
   assign rb = ir[3:0];

   assign last_pc   = (pc == PW'(PROG_DEPTH - 1));
   assign reg_rdata = rf[reg_addr];

   // Opcode classification
   always_comb begin
      is_alu  = 1'b0;
      is_nop  = 1'b0;
      is_clr  = 1'b0;
      is_halt = 1'b0;
      case (op)
         4'h4, 4'h5, 4'h8, 4'h9,
         4'hA, 4'hB, 4'hC, 4'hD: is_alu  = 1'b1;
         4'h0:                   is_nop  = 1'b1;
         4'h1:                   is_clr  = 1'b1;
         4'hF:                   is_halt = 1'b1;
         default:                ;
      endcase
      is_ill = !(is_alu || is_nop || is_clr || is_halt);
   end

   // Next-state and status outputs
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_FETCH;
         S_FETCH: begin
            busy     = 1'b1;
            state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            busy = 1'b1;
            if (is_alu)
               state_nx = (ALU_LATENCY > 0) ? S_WAIT : S_WB;
            else if (is_halt || is_ill)
               state_nx = S_DONE;
            else
               state_nx = last_pc ? S_DONE : S_FETCH;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (wcnt == 3'd0) state_nx = S_WB;
         end
         S_WB: begin
            busy     = 1'b1;
            state_nx = last_pc ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Program memory is deliberately not reset so a program survives rst.
   always_ff @(posedge clk) begin
      if (prog_we && state == S_IDLE) prog[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= '0;
         ir         <= '0;
         wcnt       <= '0;
         err        <= 1'b0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         for (int i = 0; i < 16; i++) rf[i] <= '0;
`ifdef SEQ_FLAGS_EN
         zero_flag  <= 1'b0;
         neg_flag   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc  <= '0;
                  err <= 1'b0;
               end
               if (reg_we) rf[reg_addr] <= reg_wdata;
            end
            S_FETCH: ir <= prog[pc];
            S_ISSUE: begin
               if (is_alu) begin
                  alu_opcode <= op;
                  alu_a      <= rf[ra];
                  alu_b      <= rf[rb];
                  // WAIT exits when the counter hits zero, so load L-1
                  wcnt       <= (ALU_LATENCY > 0) ? 3'(ALU_LATENCY - 1) : 3'd0;
               end
               if (is_clr) begin
                  rf[rd] <= '0;
`ifdef SEQ_FLAGS_EN
                  zero_flag <= 1'b1;
                  neg_flag  <= 1'b0;
`endif
               end
               if (is_ill) err <= 1'b1;
               if (state_nx == S_FETCH) pc <= pc + PW'(1);
            end
            S_WAIT: wcnt <= wcnt - 3'd1;
            S_WB: begin
               rf[rd]     <= alu_result;
               alu_opcode <= 4'h0;
`ifdef SEQ_FLAGS_EN
               zero_flag  <= (alu_result == 16'h0000);
               neg_flag   <= alu_result[15];
`endif
               if (state_nx == S_FETCH) pc <= pc + PW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer. Two instances share the host bus: u_a
// (PROG_DEPTH=16, combinational ALU) and u_b (PROG_DEPTH=4, 2-cycle ALU);
// 'sel' picks which one gets program writes/start and which one is observed.
// A reference model executes each program and pushes the expected results
// to a scoreboard queue, which is popped as the DUT finishes.

module tb_alu_sequencer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, prog_we, reg_we, start, sel;
   logic [3:0]  prog_addr, reg_addr;
   logic [15:0] prog_data, reg_wdata;

   logic [15:0] rdata_a, rdata_b, a_a, b_a, a_b, b_b, res_a, res_b, p0, p1;
   logic [3:0]  op_a, op_b;
   logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
`ifdef SEQ_FLAGS_EN
   logic        zf_a, nf_a, zf_b, nf_b;
`endif

   function automatic logic [15:0] alu_f(input logic [3:0] op,
                                         input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'h4:    return a + b;
         4'h5:    return a - b;
         4'h8:    return a & b;
         4'h9:    return a | b;
         4'hA:    return a ^ b;
         4'hB:    return ~(a & b);
         4'hC:    return ~(a | b);
         4'hD:    return ~a;
         default: return 16'h0000;
      endcase
   endfunction

   // ALU models: u_a combinational, u_b two-stage pipeline
   assign res_a = alu_f(op_a, a_a, b_a);
   always @(posedge clk) begin
      p0 <= alu_f(op_b, a_b, b_b);
      p1 <= p0;
   end
   assign res_b = p1;

   alu_sequencer #(.PROG_DEPTH(16), .ALU_LATENCY(0)) u_a (
      .clk(clk), .rst(rst),
      .prog_we(prog_we & ~sel), .prog_addr(prog_addr), .prog_data(prog_data),
      .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(rdata_a), .start(start & ~sel),
      .busy(busy_a), .done(done_a), .err(err_a),
      .alu_opcode(op_a), .alu_a(a_a), .alu_b(b_a), .alu_result(res_a)
`ifdef SEQ_FLAGS_EN
      , .zero_flag(zf_a), .neg_flag(nf_a)
`endif
   );

   alu_sequencer #(.PROG_DEPTH(4), .ALU_LATENCY(2)) u_b (
      .clk(clk), .rst(rst),
      .prog_we(prog_we & sel), .prog_addr(prog_addr[1:0]), .prog_data(prog_data),
      .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(rdata_b), .start(start & sel),
      .busy(busy_b), .done(done_b), .err(err_b),
      .alu_opcode(op_b), .alu_a(a_b), .alu_b(b_b), .alu_result(res_b)
`ifdef SEQ_FLAGS_EN
      , .zero_flag(zf_b), .neg_flag(nf_b)
`endif
   );

   logic        busy, done, err;
   logic [3:0]  opc;
   logic [15:0] rdata, oa, ob;
   assign busy  = sel ? busy_b  : busy_a;
   assign done  = sel ? done_b  : done_a;
   assign err   = sel ? err_b   : err_a;
   assign opc   = sel ? op_b    : op_a;
   assign rdata = sel ? rdata_b : rdata_a;
   assign oa    = sel ? a_b     : a_a;
   assign ob    = sel ? b_b     : b_a;

   // Reference model state, index 0 = u_a, 1 = u_b
   logic [15:0] mprog [2][16];
   logic [15:0] mrf   [2][16];
   logic        mzf [2];
   logic        mnf [2];
   int          lat [2];
   int          dep [2];

   string       q_tag [$];
   logic [31:0] q_exp [$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      q_tag.push_back(tag);
      q_exp.push_back(v);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      if (q_tag.size() == 0) begin
         chk("sb_underflow", 1, 0);
      end else begin
         chk(q_tag.pop_front(), obs, q_exp.pop_front());
      end
   endtask

   task automatic preload(input int r, input logic [15:0] v);
      reg_we = 1'b1; reg_addr = 4'(r); reg_wdata = v;
      @(posedge clk); #1;
      reg_we = 1'b0;
      mrf[0][r] = v;
      mrf[1][r] = v;
   endtask

   task automatic wr_prog(input int a, input logic [15:0] d);
      prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
      @(posedge clk); #1;
      prog_we = 1'b0;
      mprog[sel][a] = d;
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int r = 0; r < 16; r++) mrf[s][r] = 16'h0;
         mzf[s] = 1'b0;
         mnf[s] = 1'b0;
      end
   endtask

   // Execute the selected instance's program on the model; queue expectations.
   task automatic model_push();
      int s, pc, cyc;
      bit e, fin;
      logic [15:0] w, v;
      s = int'(sel); pc = 0; cyc = 0; e = 1'b0;
      for (int k = 0; k < 300; k++) begin
         w   = mprog[s][pc];
         fin = 1'b0;
         case (w[15:12])
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
               v = alu_f(w[15:12], mrf[s][w[7:4]], mrf[s][w[3:0]]);
               mrf[s][w[11:8]] = v;
               mzf[s] = (v == 16'h0);
               mnf[s] = v[15];
               cyc += 3 + lat[s];
            end
            4'h0: cyc += 2;
            4'h1: begin
               mrf[s][w[11:8]] = 16'h0;
               mzf[s] = 1'b1;
               mnf[s] = 1'b0;
               cyc += 2;
            end
            4'hF: begin cyc += 2; fin = 1'b1; end
            default: begin cyc += 2; e = 1'b1; fin = 1'b1; end
         endcase
         if (!fin) begin
            if (pc == dep[s] - 1) fin = 1'b1;
            else pc++;
         end
         if (fin) break;
      end
      push("busy_cycles", cyc);
      push("done_pulses", 1);
      push("err", e);
`ifdef SEQ_FLAGS_EN
      push("zero_flag", mzf[s]);
      push("neg_flag", mnf[s]);
`endif
      for (int r = 0; r < 16; r++) push($sformatf("rf%0d", r), mrf[s][r]);
   endtask

   // Start the selected instance, measure the run, compare against the queue.
   task automatic run(input bit poke);
      int  cnt, dcnt, it;
      bit  seen;
      cnt = 0; dcnt = 0; it = 0; seen = 1'b0;
      model_push();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (it < 400) begin
         if (busy) cnt++;
         if (done) begin
            dcnt++;
            seen = 1'b1;
         end else if (seen) begin
            break;
         end
         // start pulses while busy must be ignored
         if (poke) start = busy && (cnt % 3 == 1);
         @(posedge clk); #1;
         it++;
      end
      start = 1'b0;
      if (!seen) chk("run_timeout", 1, 0);
      chk("idle_opcode", opc, 0);
      pop_chk(cnt);
      pop_chk(dcnt);
      pop_chk(err);
`ifdef SEQ_FLAGS_EN
      pop_chk(sel ? zf_b : zf_a);
      pop_chk(sel ? nf_b : nf_a);
`endif
      for (int r = 0; r < 16; r++) begin
         reg_addr = 4'(r);
         #1;
         pop_chk(rdata);
      end
   endtask

   task automatic std_regs();
      preload(1, 16'h0003);
      preload(2, 16'h0005);
   endtask

   initial begin
      lat[0] = 0; lat[1] = 2;
      dep[0] = 16; dep[1] = 4;
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++) mprog[s][a] = 16'hF000;
      rst = 1'b1; prog_we = 1'b0; reg_we = 1'b0; start = 1'b0; sel = 1'b0;
      prog_addr = '0; reg_addr = '0; prog_data = '0; reg_wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state of both instances
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_opcode", opc, 0);
         chk("rst_alu_a", oa, 0);
         chk("rst_alu_b", ob, 0);
         chk("rst_rf7", rdata, 0);
      end
      // u_b's program memory is unknown after power-up; fill it with HALT
      sel = 1'b1;
      for (int a = 0; a < 4; a++) wr_prog(a, 16'hF000);

      // ADD then HALT, combinational ALU
      sel = 1'b0;
      std_regs();
      wr_prog(0, 16'h4312);
      wr_prog(1, 16'hF000);
      run(1'b0);

      // SUB wrap-around and NOT on both latencies
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         std_regs();
         wr_prog(0, 16'h5412);
         wr_prog(1, 16'hD510);
         wr_prog(2, 16'hF000);
         run(1'b0);
      end

      // CLR, NOP, illegal op stops before the ADD
      sel = 1'b0;
      std_regs();
      preload(3, 16'h0077);
      wr_prog(0, 16'h1100);
      wr_prog(1, 16'h0000);
      wr_prog(2, 16'h2312);
      wr_prog(3, 16'h4312);
      run(1'b0);

      // Four ADDs, no HALT: ends at last pc, start pokes ignored
      sel = 1'b1;
      std_regs();
      wr_prog(0, 16'h4312);
      wr_prog(1, 16'h4431);
      wr_prog(2, 16'h4544);
      wr_prog(3, 16'h4652);
      run(1'b1);

      // Reset during WAIT of an ADD
      sel = 1'b1;
      std_regs();
      wr_prog(0, 16'h4312);
      wr_prog(1, 16'hF000);
      start = 1'b1;
      @(posedge clk); #1;              // FETCH
      start = 1'b0;
      @(posedge clk); #1;              // ISSUE
      @(posedge clk); #1;              // WAIT
      chk("wait_opcode", opc, 4'h4);
      chk("wait_alu_a", oa, 16'h0003);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("midrst_busy", busy, 0);
      chk("midrst_opcode", opc, 0);
      chk("midrst_alu_a", oa, 0);
      for (int r = 0; r < 16; r++) begin
         reg_addr = 4'(r);
         #1;
         chk($sformatf("midrst_rf%0d", r), rdata, 0);
      end
      for (int i = 0; i < 3; i++) begin
         chk("midrst_no_done", done, 0);
         @(posedge clk); #1;
      end
      // program memory survived; rerun without reloading
      std_regs();
      run(1'b0);

`ifdef SEQ_FLAGS_EN
      sel = 1'b0;
      std_regs();
      wr_prog(0, 16'h5311);
      wr_prog(1, 16'hF000);
      run(1'b0);
      wr_prog(0, 16'h5312);
      run(1'b0);
`endif

      chk("sb_empty", q_tag.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
